// File: rtl/wb_mem_responder_pkg.sv
// +--------------------------------------------------------------------+
// | wb_mem_responder_pkg                                               |
// | Shared widths, burst constants and FSM state type for the          |
// | Wishbone memory responder and its burst counter.                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`include "config.v"
`default_nettype none

package wb_mem_responder_pkg;

  localparam int unsigned ADDR_W = `WB_ADDR_W;
  localparam int unsigned DATA_W = `RW;
  localparam int unsigned BURST4 = `WB_BURST_4;
  localparam int unsigned BURST8 = `WB_BURST_8;
  localparam int unsigned CTR_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Terminal beat index (N-1) for the selected burst length.
  function automatic logic [CTR_W-1:0] burst_last(input logic len8);
    return len8 ? CTR_W'(BURST8 - 1) : CTR_W'(BURST4 - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/config.v
// +--------------------------------------------------------------------+
// | config.v                                                           |
// | Bus-wide configuration shared by the Wishbone memory responder:    |
// | address/data widths and the supported burst lengths.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`ifndef WB_CONFIG_V
`define WB_CONFIG_V

// Wishbone word-address width.
`define WB_ADDR_W 24
// Wishbone data-word width.
`define RW 16
// Supported burst lengths, in words.
`define WB_BURST_4 4
`define WB_BURST_8 8

`endif

// File: rtl/wb_burst_ctr.sv
// +--------------------------------------------------------------------+
// | wb_burst_ctr                                                       |
// | Beat counter for wrapping burst reads. Holds the index of the next |
// | beat to issue and produces the wrapped low address bits.           |
// | Ports:                                                             |
// |   i_clk, i_rst      clock, synchronous active-high reset           |
// |   i_start           load a new burst (beat 0 issued this cycle)    |
// |   i_len8            1 = 8-word burst, 0 = 4-word burst             |
// |   i_start_low       low 3 bits of the starting word offset         |
// |   i_advance         a beat was issued, step to the next one        |
// |   i_clear           return the counter to 0                        |
// |   o_low             wrapped low address bits of the current beat   |
// |   o_last            current beat is the terminal one (N-1)         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_burst_ctr
  import wb_mem_responder_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_len8,
  input  logic [CTR_W-1:0] i_start_low,
  input  logic             i_advance,
  input  logic             i_clear,
  output logic [CTR_W-1:0] o_low,
  output logic             o_last
);

  logic [CTR_W-1:0] beat_q, beat_d;
  logic [CTR_W-1:0] low0_q, low0_d;
  logic             len8_q, len8_d;

  always_comb begin
    beat_d = beat_q;
    low0_d = low0_q;
    len8_d = len8_q;
    if (i_start) begin
      // Beat 0 goes out in the start cycle, so the next one is beat 1.
      beat_d = CTR_W'(1);
      low0_d = i_start_low;
      len8_d = i_len8;
    end else if (i_clear) begin
      beat_d = '0;
    end else if (i_advance) begin
      beat_d = beat_q + CTR_W'(1);
    end
  end

  // 8-word bursts wrap over all three bits; 4-word bursts keep bit 2 fixed.
  always_comb begin
    if (len8_q) begin
      o_low = low0_q + beat_q;
    end else begin
      o_low = {low0_q[2], low0_q[1:0] + beat_q[1:0]};
    end
  end

  assign o_last = (beat_q == burst_last(len8_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_q <= '0;
      low0_q <= '0;
      len8_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      low0_q <= low0_d;
      len8_q <= len8_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_mem_responder.sv
// +--------------------------------------------------------------------+
// | wb_mem_responder                                                   |
// | Wishbone slave serving a window of 16-bit words from a synchronous |
// | memory. Single reads/writes, and 4/8-beat wrapping burst reads.    |
// | Ports:                                                             |
// |   i_clk, i_rst          clock, synchronous active-high reset       |
// |   wb_cyc/stb/we/adr/sel/i_dat, wb_4_burst/wb_8_burst  master side  |
// |   wb_o_dat/ack/err/rty  slave responses (rty tied low)             |
// |   mem_addr/re/we/wmask/wdata/rdata  synchronous memory port        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32768,
  parameter int unsigned BASE_ADR  = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         wb_cyc,
  input  logic                         wb_stb,
  input  logic                         wb_we,
  input  logic [ADDR_W-1:0]            wb_adr,
  input  logic [1:0]                   wb_sel,
  input  logic [DATA_W-1:0]            wb_i_dat,
  input  logic                         wb_4_burst,
  input  logic                         wb_8_burst,
  output logic [DATA_W-1:0]            wb_o_dat,
  output logic                         wb_ack,
  output logic                         wb_err,
  output logic                         wb_rty,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [1:0]                   mem_wmask,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned       MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0]   WORDS_EXT = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [MEM_AW-1:0] BLK_MASK  = ~MEM_AW'(BURST8 - 1);

  state_e              state_q, state_d;
  logic                blk_q;            // first cycle after reset: no new transfer
  logic [MEM_AW-1:0]   base_q, base_d;   // starting offset of the current burst
  logic                resp_err_q, resp_err_d;
  logic                resp_rd_q, resp_rd_d;
  logic [DATA_W-1:0]   dat_q, dat_d;

  logic [ADDR_W-1:0]   off;
  logic                oor;
  logic                req;
  logic                is_burst;
  logic                ack_rd;
  logic                ctr_start, ctr_adv, ctr_clr;
  logic [CTR_W-1:0]    ctr_low;
  logic                ctr_last;

  // Addresses below BASE_ADR wrap to large offsets and land out of range.
  assign off      = wb_adr - ADDR_W'(BASE_ADR);
  assign oor      = ({1'b0, off} >= WORDS_EXT);
  assign req      = wb_cyc & wb_stb & ~blk_q;
  assign is_burst = wb_4_burst | wb_8_burst;
  assign wb_rty   = 1'b0;

  wb_burst_ctr u_ctr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (ctr_start),
    .i_len8      (wb_8_burst),
    .i_start_low (off[CTR_W-1:0]),
    .i_advance   (ctr_adv),
    .i_clear     (ctr_clr),
    .o_low       (ctr_low),
    .o_last      (ctr_last)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    resp_err_d = resp_err_q;
    resp_rd_d  = resp_rd_q;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = off[MEM_AW-1:0];
    mem_wmask  = 2'b00;
    mem_wdata  = wb_i_dat;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    ack_rd     = 1'b0;
    ctr_start  = 1'b0;
    ctr_adv    = 1'b0;
    ctr_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_DONE;
          resp_err_d = 1'b0;
          resp_rd_d  = 1'b0;
          if (oor || (wb_we && is_burst)) begin
            resp_err_d = 1'b1;
          end else if (wb_we) begin
            mem_we    = 1'b1;
            mem_wmask = wb_sel;
          end else begin
            mem_re = 1'b1;
            if (is_burst) begin
              ctr_start = 1'b1;
              base_d    = off[MEM_AW-1:0];
              state_d   = ST_BEAT;
            end else begin
              resp_rd_d = 1'b1;
            end
          end
        end
      end

      ST_BEAT: begin
        if (!wb_cyc) begin
          // Master abandoned the burst: stop reading and stay silent.
          ctr_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // Acknowledge the previous beat while issuing the current one.
          wb_ack   = 1'b1;
          ack_rd   = 1'b1;
          mem_re   = 1'b1;
          mem_addr = (base_q & BLK_MASK) | MEM_AW'(ctr_low);
          if (ctr_last) begin
            resp_err_d = 1'b0;
            resp_rd_d  = 1'b1;
            state_d    = ST_DONE;
          end else begin
            ctr_adv = 1'b1;
          end
        end
      end

      ST_DONE: begin
        wb_ack  = ~resp_err_q;
        wb_err  = resp_err_q;
        ack_rd  = resp_rd_q;
        ctr_clr = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read data is forwarded straight from memory on a read ack, held otherwise.
  assign dat_d    = ack_rd ? mem_rdata : dat_q;
  assign wb_o_dat = dat_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      blk_q      <= 1'b1;
      base_q     <= '0;
      resp_err_q <= 1'b0;
      resp_rd_q  <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= 1'b0;
      base_q     <= base_d;
      resp_err_q <= resp_err_d;
      resp_rd_q  <= resp_rd_d;
      dat_q      <= dat_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
// +--------------------------------------------------------------------+
// | tb_wb_mem_responder                                                |
// | Self-checking bench for wb_mem_responder: directed cases followed  |
// | by random transfers against a cycle-indexed reference model.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_wb_mem_responder;
  import wb_mem_responder_pkg::*;

  localparam int MW = 1024;
  localparam int BA = 'h4000;
  localparam int AW = $clog2(MW);
  localparam int NC = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we, b4, b8;
  logic [ADDR_W-1:0] adr;
  logic [1:0]        sel;
  logic [15:0]       idat, odat;
  logic              ack, err, rty;
  logic [AW-1:0]     maddr;
  logic              mre, mwe;
  logic [1:0]        mmask;
  logic [15:0]       mwdata, mrdata;

  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [15:0]       load_dat;

  logic [15:0] sim_mem [MW];
  logic [15:0] ref_mem [MW];
  logic [15:0] last_dat;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.MEM_WORDS(MW), .BASE_ADR(BA)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .wb_cyc     (cyc),
    .wb_stb     (stb),
    .wb_we      (we),
    .wb_adr     (adr),
    .wb_sel     (sel),
    .wb_i_dat   (idat),
    .wb_4_burst (b4),
    .wb_8_burst (b8),
    .wb_o_dat   (odat),
    .wb_ack     (ack),
    .wb_err     (err),
    .wb_rty     (rty),
    .mem_addr   (maddr),
    .mem_re     (mre),
    .mem_we     (mwe),
    .mem_wmask  (mmask),
    .mem_wdata  (mwdata),
    .mem_rdata  (mrdata)
  );

  // Synchronous memory: read data one cycle later, masked byte writes.
  always @(posedge clk) begin
    if (load_en) begin
      sim_mem[load_addr] <= load_dat;
    end else if (mwe) begin
      if (mmask[0]) sim_mem[maddr][7:0]  <= mwdata[7:0];
      if (mmask[1]) sim_mem[maddr][15:8] <= mwdata[15:8];
    end
    if (mre) mrdata <= sim_mem[maddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer starting at posedge+1. drop_at: cycle where the master
  // releases cyc; rst_at: cycle in which reset is held high (-1 = unused).
  task automatic run_txn(input logic t_we, input logic [ADDR_W-1:0] t_adr,
                         input logic [1:0] t_sel, input logic [15:0] t_dat,
                         input logic t_b4, input logic t_b8,
                         input int drop_at, input int rst_at);
    logic        e_ack [NC];
    logic        e_err [NC];
    logic        e_re  [NC];
    logic        e_we  [NC];
    logic        e_rdv [NC];
    int          e_addr[NC];
    logic [15:0] e_dat [NC];
    int off, n, last, cut, hi_end, a;

    for (int c = 0; c < NC; c++) begin
      e_ack[c] = 0; e_err[c] = 0; e_re[c] = 0; e_we[c] = 0; e_rdv[c] = 0;
      e_addr[c] = 0; e_dat[c] = '0;
    end

    off = int'(t_adr) - BA;
    if (off < 0 || off >= MW || (t_we && (t_b4 || t_b8))) begin
      e_err[1] = 1;
      last = 1;
    end else if (t_we) begin
      e_we[0] = 1;
      e_addr[0] = off;
      e_ack[1] = 1;
      last = 1;
    end else begin
      n = t_b8 ? 8 : (t_b4 ? 4 : 1);
      for (int k = 0; k < n; k++) begin
        a = (off / n) * n + (off + k) % n;
        e_re[k] = 1;
        e_addr[k] = a;
        e_ack[k+1] = 1;
        e_rdv[k+1] = 1;
        e_dat[k+1] = ref_mem[a];
      end
      last = n;
    end

    cut = NC;
    hi_end = last;
    if (drop_at >= 0) begin cut = drop_at; hi_end = drop_at - 1; end
    if (rst_at >= 0) begin cut = rst_at + 1; hi_end = rst_at + 1; end
    for (int c = 0; c < NC; c++) begin
      if (c >= cut) begin
        e_ack[c] = 0; e_err[c] = 0; e_re[c] = 0; e_we[c] = 0; e_rdv[c] = 0;
      end
    end

    we = t_we; adr = t_adr; sel = t_sel; idat = t_dat; b4 = t_b4; b8 = t_b8;
    for (int c = 0; c < NC; c++) begin
      cyc = (c <= hi_end);
      stb = (c <= hi_end);
      rst = (c == rst_at);
      #2;
      if (rst_at >= 0 && c == rst_at + 1) last_dat = '0;
      if (e_rdv[c]) last_dat = e_dat[c];
      check($sformatf("ctl c%0d off%0h", c, off), {ack, err, rty, mre, mwe},
            {e_ack[c], e_err[c], 1'b0, e_re[c], e_we[c]});
      if (e_re[c] || e_we[c])
        check($sformatf("addr c%0d", c), 32'(maddr), 32'(e_addr[c]));
      if (e_we[c])
        check($sformatf("wr c%0d", c), {mmask, mwdata}, {t_sel, t_dat});
      check($sformatf("odat c%0d off%0h", c, off), 32'(odat), 32'(last_dat));
      @(posedge clk); #1;
    end
    rst = 1'b0;

    if (e_we[0]) begin
      if (t_sel[0]) ref_mem[off][7:0]  = t_dat[7:0];
      if (t_sel[1]) ref_mem[off][15:8] = t_dat[15:8];
    end
  endtask

  initial begin
    logic [15:0] d;
    int kind, off;
    logic rw, f4, f8;

    rst = 1'b1; cyc = 0; stb = 0; we = 0; adr = '0; sel = 2'b11; idat = '0;
    b4 = 0; b8 = 0; load_en = 1'b0; load_addr = '0; load_dat = '0;
    last_dat = '0;

    @(posedge clk); #1;
    for (int i = 0; i < MW; i++) begin
      d = (i == 'h10) ? 16'hBEEF : 16'($urandom);
      load_en = 1'b1; load_addr = AW'(i); load_dat = d;
      ref_mem[i] = d;
      @(posedge clk); #1;
    end
    load_en = 1'b0;

    #2;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_odat", 32'(odat), 32'd0);
    check("rst_strobes", {mre, mwe}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Directed cases.
    run_txn(0, ADDR_W'(BA + 'h10),  2'b11, 16'h0000, 0, 0, -1, -1);
    run_txn(1, ADDR_W'(BA + 5),     2'b01, 16'hA55A, 0, 0, -1, -1);
    run_txn(0, ADDR_W'(BA + 5),     2'b00, 16'h0000, 0, 0, -1, -1);
    run_txn(0, ADDR_W'(BA + 'h106), 2'b11, 16'h0000, 0, 1, -1, -1);
    run_txn(0, ADDR_W'(BA + MW),    2'b11, 16'h0000, 0, 0, -1, -1);
    run_txn(1, ADDR_W'(BA + 'h20),  2'b11, 16'h1234, 1, 0, -1, -1);
    run_txn(0, ADDR_W'(BA + 'h35),  2'b11, 16'h0000, 1, 0, -1, -1);
    run_txn(0, ADDR_W'(BA + 'h31),  2'b11, 16'h0000, 1, 0,  3, -1);
    run_txn(0, ADDR_W'(BA + 'h40),  2'b11, 16'h0000, 0, 0, -1, -1);
    run_txn(0, ADDR_W'(BA + 'h203), 2'b11, 16'h0000, 0, 1, -1,  4);
    run_txn(0, ADDR_W'(BA - 1),     2'b11, 16'h0000, 0, 0, -1, -1);

    // Random transfers.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 9));
      off  = int'($urandom_range(0, MW - 1));
      rw   = ($urandom_range(0, 2) == 0);
      f4   = 1'b0;
      f8   = 1'b0;
      if (!rw || $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          1: f4 = 1'b1;
          2: f8 = 1'b1;
          3: begin f4 = 1'b1; f8 = 1'b1; end
          default: ;
        endcase
      end
      if (kind == 0) off = MW + int'($urandom_range(0, 100));
      if (kind == 1) off = -1 - int'($urandom_range(0, 100));
      run_txn(rw, ADDR_W'(BA + off), 2'($urandom), 16'($urandom), f4, f8, -1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
